// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction fetch / data) to one 64-bit memory bus arbiter with
// alternating priority, a registered req/ack sequencer and a bus watchdog.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [63:0] i_addr,
    input  logic        i_req,
    output logic        i_valid,
    output logic [31:0] i_data,

    input  logic [63:0] d_addr,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_ready,

    output logic [63:0] bus_addr,
    output logic        bus_req,
    output logic        bus_rw,
    output logic [63:0] bus_wdata,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_timeout
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TmoCnt = CW'(TIMEOUT);
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StBusI,
        StBusD,
        StResp
    } state_e;

    state_e        r_state;
    logic          r_last_d;
    logic [CW-1:0] r_wdog;
    logic          r_sel_hi;
    logic          r_i_valid;
    logic [31:0]   r_i_data;
    logic          r_d_ready;
    logic [63:0]   r_d_rdata;
    logic [63:0]   r_bus_addr;
    logic          r_bus_req;
    logic          r_bus_rw;
    logic [63:0]   r_bus_wdata;
    logic          r_bus_timeout;

    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_timeout;
    logic          w_done;
    logic [31:0]   w_i_word;
    logic          w_unused_addr;

    // Data wins a conflict unless it was the port served last.
    assign w_grant_d = d_req && (!i_req || !r_last_d);
    assign w_grant_i = i_req && !w_grant_d;

    assign w_timeout = (TIMEOUT != 0) && (r_wdog == TmoCnt);
    assign w_done    = bus_ack || w_timeout;
    assign w_i_word  = r_sel_hi ? bus_rdata[63:32] : bus_rdata[31:0];

    assign w_unused_addr = ^{i_addr[1:0], d_addr[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_last_d      <= 1'b0;
            r_wdog        <= '0;
            r_sel_hi      <= 1'b0;
            r_i_valid     <= 1'b0;
            r_i_data      <= '0;
            r_d_ready     <= 1'b0;
            r_d_rdata     <= '0;
            r_bus_addr    <= '0;
            r_bus_req     <= 1'b0;
            r_bus_rw      <= 1'b0;
            r_bus_wdata   <= '0;
            r_bus_timeout <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_ready <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_wdog <= '0;
                    if (w_grant_d) begin
                        r_state     <= StBusD;
                        r_bus_req   <= 1'b1;
                        r_bus_rw    <= d_rw;
                        r_bus_addr  <= {d_addr[63:3], 3'b000};
                        r_bus_wdata <= d_wdata;
                        r_last_d    <= 1'b1;
                    end else if (w_grant_i) begin
                        r_state     <= StBusI;
                        r_bus_req   <= 1'b1;
                        r_bus_rw    <= 1'b0;
                        r_bus_addr  <= {i_addr[63:3], 3'b000};
                        r_bus_wdata <= '0;
                        r_sel_hi    <= i_addr[2];
                        r_last_d    <= 1'b0;
                    end
                end
                StBusI, StBusD: begin
                    if (w_done) begin
                        r_state   <= StResp;
                        r_bus_req <= 1'b0;
                        r_bus_rw  <= 1'b0;
                        if (r_state == StBusI) begin
                            r_i_valid <= 1'b1;
                            r_i_data  <= bus_ack ? w_i_word : NopInstr;
                        end else begin
                            r_d_ready <= 1'b1;
                            if (!bus_ack) begin
                                r_d_rdata <= '1;
                            end else if (r_bus_rw) begin
                                r_d_rdata <= '0;
                            end else begin
                                r_d_rdata <= bus_rdata;
                            end
                        end
                        // An ack in the final watchdog cycle still counts as success.
                        if (!bus_ack) begin
                            r_bus_timeout <= 1'b1;
                        end
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                StResp: begin
                    r_wdog  <= '0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign i_valid     = r_i_valid;
    assign i_data      = r_i_data;
    assign d_ready     = r_d_ready;
    assign d_rdata     = r_d_rdata;
    assign bus_addr    = r_bus_addr;
    assign bus_req     = r_bus_req;
    assign bus_rw      = r_bus_rw;
    assign bus_wdata   = r_bus_wdata;
    assign bus_timeout = r_bus_timeout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: grants and responses are queued when
// stimulus is issued and checked by a negedge monitor as the DUT presents them.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [63:0] i_addr;
    logic        i_req;
    logic        i_valid;
    logic [31:0] i_data;
    logic [63:0] d_addr;
    logic        d_req;
    logic        d_rw;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_ready;
    logic [63:0] bus_addr;
    logic        bus_req;
    logic        bus_rw;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata;
    logic        bus_ack;
    logic        bus_timeout;

    mem_bus_arbiter #(
        .TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_req      (i_req),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .d_addr     (d_addr),
        .d_req      (d_req),
        .d_rw       (d_rw),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .bus_addr   (bus_addr),
        .bus_req    (bus_req),
        .bus_rw     (bus_rw),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .bus_timeout(bus_timeout)
    );

    typedef struct {
        logic [63:0] addr;
        logic        rw;
        logic [63:0] wdata;
    } grant_t;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Slave model controls
    bit   ack_en    = 1'b1;
    int   ack_delay = 1;
    bit   stray_ack = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a response pulse; n is the number of cycles waited, -1 on expiry.
    task automatic wait_pulse(input bit is_d, input int lim, output int n);
        n = -1;
        for (int k = 1; k <= lim; k++) begin
            tick();
            if ((is_d && d_ready) || (!is_d && i_valid)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic push_grant(input logic [63:0] a, input logic rw, input logic [63:0] wd);
        grant_t g;
        g.addr  = a;
        g.rw    = rw;
        g.wdata = wd;
        grant_q.push_back(g);
    endtask

    task automatic push_resp(input bit is_d, input logic [63:0] data);
        resp_t r;
        r.is_d = is_d;
        r.data = data;
        resp_q.push_back(r);
    endtask

    // Slave: acks ack_delay cycles after bus_req rises; optional stray ack while idle.
    initial begin
        int hcnt;
        hcnt      = 0;
        bus_ack   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                bus_ack = ack_en && (hcnt == ack_delay);
                hcnt++;
            end else begin
                hcnt    = 0;
                bus_ack = stray_ack;
            end
        end
    end

    // Monitor
    initial begin
        logic prev_br;
        logic prev_iv;
        logic prev_dr;
        grant_t g;
        resp_t  r;
        prev_br = 1'b0;
        prev_iv = 1'b0;
        prev_dr = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev_br) begin
                if (grant_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected grant: got addr %h want none", bus_addr);
                end else begin
                    g = grant_q.pop_front();
                    check("grant addr", bus_addr, g.addr);
                    check("grant rw", {63'd0, bus_rw}, {63'd0, g.rw});
                    if (g.rw) check("grant wdata", bus_wdata, g.wdata);
                end
            end
            if (i_valid) begin
                check("i_valid width", {63'd0, prev_iv}, 64'd0);
                if (resp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected i_valid: got data %h want none", i_data);
                end else begin
                    r = resp_q.pop_front();
                    check("resp port is I", {63'd0, r.is_d}, 64'd0);
                    check("i_data", {32'd0, i_data}, {32'd0, r.data[31:0]});
                end
            end
            if (d_ready) begin
                check("d_ready width", {63'd0, prev_dr}, 64'd0);
                if (resp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected d_ready: got data %h want none", d_rdata);
                end else begin
                    r = resp_q.pop_front();
                    check("resp port is D", {63'd0, r.is_d}, 64'd1);
                    check("d_rdata", d_rdata, r.data);
                end
            end
            prev_br = bus_req;
            prev_iv = i_valid;
            prev_dr = d_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got stuck want finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int hc;
        rst       = 1'b1;
        i_addr    = '0;
        i_req     = 1'b0;
        d_addr    = '0;
        d_req     = 1'b0;
        d_rw      = 1'b0;
        d_wdata   = '0;
        bus_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst bus_req", {63'd0, bus_req}, 64'd0);
        check("rst bus_rw", {63'd0, bus_rw}, 64'd0);
        check("rst i_valid", {63'd0, i_valid}, 64'd0);
        check("rst d_ready", {63'd0, d_ready}, 64'd0);
        check("rst bus_timeout", {63'd0, bus_timeout}, 64'd0);
        check("rst bus_addr", bus_addr, 64'd0);
        check("rst bus_wdata", bus_wdata, 64'd0);
        check("rst i_data", {32'd0, i_data}, 64'd0);
        check("rst d_rdata", d_rdata, 64'd0);

        // Stray ack in IDLE
        stray_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stray bus_req", {63'd0, bus_req}, 64'd0);
            check("stray pulses", {62'd0, i_valid, d_ready}, 64'd0);
        end
        stray_ack = 1'b0;
        tick();

        // Single fetch
        ack_delay = 1;
        bus_rdata = 64'hAAAA_BBBB_1234_5678;
        i_addr    = 64'h1004;
        i_req     = 1'b1;
        push_grant(64'h1000, 1'b0, 64'd0);
        push_resp(1'b0, 64'hAAAA_BBBB);
        wait_pulse(1'b0, 20, n);
        check("fetch latency", n, 3);
        i_req = 1'b0;
        tick();
        check("fetch pulse cleared", {63'd0, i_valid}, 64'd0);
        check("fetch bus_req low", {63'd0, bus_req}, 64'd0);
        tick();

        // Data write, slow ack; requester scribbles inputs while granted
        ack_delay = 4;
        d_addr    = 64'h2000;
        d_rw      = 1'b1;
        d_wdata   = 64'hDEAD_BEEF_0000_0001;
        d_req     = 1'b1;
        push_grant(64'h2000, 1'b1, 64'hDEAD_BEEF_0000_0001);
        push_resp(1'b1, 64'd0);
        tick();
        tick();
        d_addr  = 64'hFFFF_0000;
        d_rw    = 1'b0;
        d_wdata = 64'd0;
        tick();
        check("write addr held", bus_addr, 64'h2000);
        check("write rw held", {63'd0, bus_rw}, 64'd1);
        check("write wdata held", bus_wdata, 64'hDEAD_BEEF_0000_0001);
        wait_pulse(1'b1, 20, n);
        check("write latency", n, 3);
        check("i_data kept", {32'd0, i_data}, 64'hAAAA_BBBB);
        d_req = 1'b0;
        tick();

        // Conflict after reset: D first, then I, then D's second request
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        ack_delay = 1;
        bus_rdata = 64'h1111_2222_3333_4444;
        i_addr    = 64'h3000;
        i_req     = 1'b1;
        d_addr    = 64'h400C;
        d_rw      = 1'b0;
        d_req     = 1'b1;
        push_grant(64'h4008, 1'b0, 64'd0);
        push_resp(1'b1, 64'h1111_2222_3333_4444);
        push_grant(64'h3000, 1'b0, 64'd0);
        push_resp(1'b0, 64'h3333_4444);
        push_grant(64'h5000, 1'b0, 64'd0);
        push_resp(1'b1, 64'h1111_2222_3333_4444);
        wait_pulse(1'b1, 20, n);
        check("conflict D latency", n, 3);
        d_addr = 64'h5000;
        tick();
        tick();
        check("conflict I granted", {63'd0, bus_req}, 64'd1);
        check("conflict I addr", bus_addr, 64'h3000);
        wait_pulse(1'b0, 20, n);
        check("conflict I latency", n, 2);
        i_req = 1'b0;
        wait_pulse(1'b1, 20, n);
        check("conflict D2 latency", n, 4);
        d_req = 1'b0;
        tick();

        // Repeated conflict with D served last: I first
        i_addr  = 64'h6004;
        i_req   = 1'b1;
        d_addr  = 64'h7000;
        d_rw    = 1'b1;
        d_wdata = 64'h0123_4567_89AB_CDEF;
        d_req   = 1'b1;
        push_grant(64'h6000, 1'b0, 64'd0);
        push_resp(1'b0, 64'h1111_2222);
        push_grant(64'h7000, 1'b1, 64'h0123_4567_89AB_CDEF);
        push_resp(1'b1, 64'd0);
        tick();
        check("alt I granted", {63'd0, bus_req}, 64'd1);
        check("alt I addr", bus_addr, 64'h6000);
        wait_pulse(1'b0, 20, n);
        check("alt I latency", n, 2);
        i_req = 1'b0;
        wait_pulse(1'b1, 20, n);
        check("alt D latency", n, 4);
        d_req = 1'b0;
        tick();

        // Watchdog: slave never acks
        ack_en = 1'b0;
        d_addr = 64'h8000;
        d_rw   = 1'b0;
        d_req  = 1'b1;
        push_grant(64'h8000, 1'b0, 64'd0);
        push_resp(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        hc = 0;
        n  = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus_req) hc++;
            if (d_ready) begin
                n = k;
                break;
            end
        end
        check("timeout bus_req cycles", hc, 9);
        check("timeout latency", n, 10);
        check("timeout flag", {63'd0, bus_timeout}, 64'd1);
        d_req  = 1'b0;
        ack_en = 1'b1;
        tick();

        // Good fetch after timeout: flag stays set
        bus_rdata = 64'hCAFE_F00D_5555_6666;
        i_addr    = 64'h104;
        i_req     = 1'b1;
        push_grant(64'h100, 1'b0, 64'd0);
        push_resp(1'b0, 64'hCAFE_F00D);
        wait_pulse(1'b0, 20, n);
        check("post-timeout fetch latency", n, 3);
        i_req = 1'b0;
        tick();
        check("timeout sticky", {63'd0, bus_timeout}, 64'd1);
        tick();

        // Reset two cycles into BUS_I; late ack must be ignored
        ack_delay = 5;
        i_addr    = 64'h9000;
        i_req     = 1'b1;
        push_grant(64'h9000, 1'b0, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst bus_req", {63'd0, bus_req}, 64'd0);
        check("midrst i_valid", {63'd0, i_valid}, 64'd0);
        check("midrst bus_timeout", {63'd0, bus_timeout}, 64'd0);
        check("midrst bus_addr", bus_addr, 64'd0);
        check("midrst i_data", {32'd0, i_data}, 64'd0);
        check("midrst d_rdata", d_rdata, 64'd0);
        rst       = 1'b0;
        i_req     = 1'b0;
        stray_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("late ack bus_req", {63'd0, bus_req}, 64'd0);
            check("late ack pulses", {62'd0, i_valid, d_ready}, 64'd0);
        end
        stray_ack = 1'b0;
        repeat (3) tick();

        check("grant queue drained", grant_q.size(), 0);
        check("resp queue drained", resp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port-to-one memory arbiter sitting between `cpu_core` and the single SoC memory bus. It shares one 64-bit downstream bus between the core's instruction-fetch port (read-only, 32-bit instructions) and its data port (read/write, 64-bit). It provides alternating-priority arbitration, a registered request/acknowledge sequencer and a bus watchdog that terminates transactions the slave never acknowledges.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles `bus_req` may stay high without `bus_ack` before forced termination; 0 disables the watchdog.

Ports:
- Clock and reset: single clock `clk`; `rst` is synchronous, active-high.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `i_addr`  in  64  fetch address (core `inst_mem_addr`).
- `i_req`  in  1  fetch request, level, held until `i_valid` (core `inst_addr_valid`).
- `i_valid`  out  1  one-cycle fetch-done pulse (core `inst_mem_valid`).
- `i_data`  out  32  fetched instruction (core `inst_mem_data`).
- `d_addr`  in  64  data address.
- `d_req`  in  1  data request, level (core `data_mem_addr_valid`).
- `d_rw`  in  1  1 = write, 0 = read.
- `d_wdata`  in  64  write data.
- `d_rdata`  out  64  read data.
- `d_ready`  out  1  one-cycle data-done pulse.
- `bus_addr`  out  64  downstream address, 8-byte aligned (`addr[2:0]` forced 0).
- `bus_req`  out  1  downstream request, level.
- `bus_rw`  out  1  downstream write strobe.
- `bus_wdata`  out  64  downstream write data.
- `bus_rdata`  in  64  downstream read data, valid with `bus_ack`.
- `bus_ack`  in  1  downstream completion, sampled only while `bus_req`=1.
- `bus_timeout`  out  1  sticky watchdog-fired flag.

## Operation
- States: IDLE, BUS_I, BUS_D, RESP.
- IDLE:
  - Sample `i_req`/`d_req`. None pending: stay in IDLE.
  - One pending: grant it.
  - Both pending: grant the port not served last (`last_grant`). Reset value of `last_grant` = I, so data wins the first conflict.
  - On grant: latch address, `rw` and `wdata` into bus registers; set `last_grant`; go to BUS_I or BUS_D.
- BUS_I / BUS_D:
  - `bus_req`=1, `bus_rw`=0 for I and `d_rw` (latched) for D.
  - Watchdog counter increments each cycle.
  - `bus_ack`=1: capture data and go to RESP.
  - Counter reaches `TIMEOUT` with no ack: go to RESP with error data, set `bus_timeout`.
- RESP:
  - One cycle. `bus_req`=0; pulse `i_valid` or `d_ready`.
  - Requests are ignored this cycle so a requester's stale level is never re-granted.
  - Next state is IDLE.
- Data formatting:
  - `i_data` = `bus_rdata[63:32]` if latched `i_addr[2]`=1, else `bus_rdata[31:0]`.
  - `d_rdata` = `bus_rdata` on reads, 0 on writes.
  - On timeout, `i_data` = 32'h0000_0013 (NOP) and `d_rdata` = all ones.
- `i_data`/`d_rdata` hold their value until the next response of the same port.
- Requester changing address/`rw` while granted: ignored (latched values used).

## Timing
- All outputs registered. Reset values:
  - `bus_req`, `bus_rw`, `i_valid`, `d_ready`, `bus_timeout` = 0.
  - `bus_addr`, `bus_wdata`, `i_data`, `d_rdata` = 0.
  - State = IDLE, `last_grant` = I, watchdog = 0.
- Request seen in IDLE at cycle N:
  - `bus_req`=1 from N+1.
  - `bus_ack` seen at cycle M ≥ N+1.
  - Response pulse at M+1, `bus_req`=0 at M+1.
  - IDLE at M+2.
  - Minimum request-to-response latency: 2 cycles. Minimum issue interval: 3 cycles.
- `bus_ack` while `bus_req`=0 (IDLE/RESP) is ignored.
- Watchdog: with `TIMEOUT`=T, if no ack arrives, the response occurs exactly T+1 cycles after `bus_req` rises. Counter clears on entering IDLE.
- Back-to-back conflict: while D is served, I stays pending; I is granted in the IDLE cycle after RESP (alternation). No starvation; worst-case wait = one foreign transaction.
- `rst` mid-transaction:
  - Next edge forces IDLE; `bus_req` is 0 and no response pulse is issued.
  - The abandoned bus transaction is the slave's responsibility.
  - `bus_timeout` clears only on `rst`.

## Test plan
- Single fetch: `i_addr`=0x1004, `i_req`=1, slave acks 1 cycle after `bus_req` with `bus_rdata`=0xAAAA_BBBB_1234_5678 → `bus_addr`=0x1000, `i_data`=0xAAAA_BBBB, `i_valid` high exactly 1 cycle, 3 cycles after request.
- Data write: `d_addr`=0x2000, `d_rw`=1, `d_wdata`=0xDEAD_BEEF_0000_0001, ack after 4 cycles → `bus_rw`=1, `bus_wdata` matches, `d_ready` pulse once, `d_rdata`=0.
- Conflict: `i_req` and `d_req` both asserted in the same cycle after reset, both held → D granted first, I granted in the IDLE cycle after D's RESP. Repeating the conflict grants I first (alternation).
- Timeout: `TIMEOUT`=8, D read, slave never acks → `bus_req` high 9 cycles, `d_ready` pulse with `d_rdata`=0xFFFF_FFFF_FFFF_FFFF, `bus_timeout`=1 and stays 1 through later good transactions.
- Reset mid-transfer: assert `rst` 2 cycles into BUS_I → next cycle all outputs at reset values, no `i_valid` pulse; a late `bus_ack` is ignored.
- Stray ack: `bus_ack`=1 in IDLE with no requests → no pulses, state stays IDLE.
